// File: rtl/systolic_ws_ctrl.sv
// Sequencer for the weight-stationary systolic array: weight load, skewed
// input streaming and skewed result write-back for one tile per start.
module systolic_ws_ctrl #(
  parameter int unsigned ROW_NUM = 8,
  parameter int unsigned COL_NUM = 8,
  parameter int unsigned LENGTH  = 8,
  parameter int unsigned OUT_LAT = 8,
  localparam int unsigned ROW_ADDR_WIDTH    = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1,
  localparam int unsigned LENGTH_ADDR_WIDTH = (LENGTH > 1) ? $clog2(LENGTH) : 1,
  localparam int unsigned T_WIDTH           = $clog2(OUT_LAT + COL_NUM + ROW_NUM + 1)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start_val,
  output logic                                   start_rdy,
  output logic                                   done,
  output logic                                   wt_rd_en,
  output logic [LENGTH_ADDR_WIDTH-1:0]           wt_rdaddr,
  output logic                                   wt_load_en,
  output logic [LENGTH_ADDR_WIDTH-1:0]           wt_load_row,
  output logic [0:LENGTH-1]                      row_rd_en,
  output logic [0:LENGTH-1][ROW_ADDR_WIDTH-1:0]  row_rdaddr,
  output logic [0:COL_NUM-1]                     row_wr_en,
  output logic [0:COL_NUM-1][ROW_ADDR_WIDTH-1:0] row_wraddr
);

  localparam int unsigned C_WIDTH = $clog2(LENGTH + 1);
  // t of the last source read and of the last result write
  localparam int unsigned LAST_RD = LENGTH + ROW_NUM - 2;
  localparam int unsigned LAST_WR = OUT_LAT + COL_NUM + ROW_NUM - 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, RUN, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [C_WIDTH-1:0]   c, c_nxt;
  logic [T_WIDTH-1:0]   t, t_nxt;
  logic [31:0]          tn;

  logic                                   done_nxt;
  logic                                   wt_rd_en_nxt;
  logic [LENGTH_ADDR_WIDTH-1:0]           wt_rdaddr_nxt;
  logic                                   wt_load_en_nxt;
  logic [LENGTH_ADDR_WIDTH-1:0]           wt_load_row_nxt;
  logic [0:LENGTH-1]                      row_rd_en_nxt;
  logic [0:LENGTH-1][ROW_ADDR_WIDTH-1:0]  row_rdaddr_nxt;
  logic [0:COL_NUM-1]                     row_wr_en_nxt;
  logic [0:COL_NUM-1][ROW_ADDR_WIDTH-1:0] row_wraddr_nxt;

  // Idle handshake; forced low while reset is held
  assign start_rdy = (state == IDLE) & reset;

  // Next state and phase counters
  always_comb begin
    state_nxt = state;
    c_nxt     = c;
    t_nxt     = t;
    unique case (state)
      IDLE: begin
        if (start_val) begin
          state_nxt = LOAD_W;
          c_nxt     = '0;
        end
      end
      LOAD_W: begin
        if (c == C_WIDTH'(LENGTH)) begin
          state_nxt = RUN;
          t_nxt     = '0;
        end else begin
          c_nxt = c + C_WIDTH'(1);
        end
      end
      RUN: begin
        t_nxt = t + T_WIDTH'(1);
        if (t == T_WIDTH'(LAST_RD)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (t >= T_WIDTH'(LAST_WR)) state_nxt = DONE;
        else                        t_nxt = t + T_WIDTH'(1);
      end
      DONE: begin
        state_nxt = IDLE;
        c_nxt     = '0;
        t_nxt     = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from next state and counters
  always_comb begin
    done_nxt        = 1'b0;
    wt_rd_en_nxt    = 1'b0;
    wt_rdaddr_nxt   = '0;
    wt_load_en_nxt  = 1'b0;
    wt_load_row_nxt = '0;
    row_rd_en_nxt   = '0;
    row_rdaddr_nxt  = '0;
    row_wr_en_nxt   = '0;
    row_wraddr_nxt  = '0;
    tn              = 32'(t_nxt);

    done_nxt = (state_nxt == DONE);

    if (state_nxt == LOAD_W) begin
      if (c_nxt < C_WIDTH'(LENGTH)) begin
        wt_rd_en_nxt  = 1'b1;
        wt_rdaddr_nxt = LENGTH_ADDR_WIDTH'(c_nxt);
      end
      // SRAM data for address c-1 arrives one cycle after its read
      if (c_nxt != '0) begin
        wt_load_en_nxt  = 1'b1;
        wt_load_row_nxt = LENGTH_ADDR_WIDTH'(c_nxt - C_WIDTH'(1));
      end
    end

    if (state_nxt == RUN || state_nxt == DRAIN) begin
      for (int unsigned k = 0; k < LENGTH; k++) begin
        if (tn >= k && tn < k + ROW_NUM) begin
          row_rd_en_nxt[k]  = 1'b1;
          row_rdaddr_nxt[k] = ROW_ADDR_WIDTH'(tn - k);
        end
      end
      for (int unsigned j = 0; j < COL_NUM; j++) begin
        if (tn >= 1 + OUT_LAT + j && tn < 1 + OUT_LAT + j + ROW_NUM) begin
          row_wr_en_nxt[j]  = 1'b1;
          row_wraddr_nxt[j] = ROW_ADDR_WIDTH'(tn - 1 - OUT_LAT - j);
        end
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      c           <= '0;
      t           <= '0;
      done        <= 1'b0;
      wt_rd_en    <= 1'b0;
      wt_rdaddr   <= '0;
      wt_load_en  <= 1'b0;
      wt_load_row <= '0;
      row_rd_en   <= '0;
      row_rdaddr  <= '0;
      row_wr_en   <= '0;
      row_wraddr  <= '0;
    end else begin
      state       <= state_nxt;
      c           <= c_nxt;
      t           <= t_nxt;
      done        <= done_nxt;
      wt_rd_en    <= wt_rd_en_nxt;
      wt_rdaddr   <= wt_rdaddr_nxt;
      wt_load_en  <= wt_load_en_nxt;
      wt_load_row <= wt_load_row_nxt;
      row_rd_en   <= row_rd_en_nxt;
      row_rdaddr  <= row_rdaddr_nxt;
      row_wr_en   <= row_wr_en_nxt;
      row_wraddr  <= row_wraddr_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_ws_ctrl.sv
// Scoreboard bench for systolic_ws_ctrl: default, small and ROW_NUM=1 builds.
module tb_systolic_ws_ctrl;

  localparam int K_WRD  = 0;
  localparam int K_WLD  = 1;
  localparam int K_RD   = 2;
  localparam int K_WR   = 3;
  localparam int K_DONE = 4;
  localparam int BIG    = 1 << 30;

  typedef struct {
    int cyc;
    int kind;
    int idx;
    int addr;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  ev_t qc[$];

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a, rst_bc, sv_a, sv_b, sv_c;

  // default build
  logic a_rdy, a_done, a_wrd, a_wld;
  logic [2:0] a_wra, a_wlr;
  logic [0:7] a_rre, a_wre;
  logic [0:7][2:0] a_rra, a_wwa;

  // ROW_NUM=4 COL_NUM=2 LENGTH=3 OUT_LAT=3
  logic b_rdy, b_done, b_wrd, b_wld;
  logic [1:0] b_wra, b_wlr;
  logic [0:2] b_rre;
  logic [0:2][1:0] b_rra;
  logic [0:1] b_wre;
  logic [0:1][1:0] b_wwa;

  // ROW_NUM=1
  logic c_rdy, c_done, c_wrd, c_wld;
  logic [2:0] c_wra, c_wlr;
  logic [0:7] c_rre, c_wre;
  logic [0:7][0:0] c_rra, c_wwa;

  systolic_ws_ctrl dut_a (
    .clk(clk), .reset(rst_a), .start_val(sv_a), .start_rdy(a_rdy), .done(a_done),
    .wt_rd_en(a_wrd), .wt_rdaddr(a_wra), .wt_load_en(a_wld), .wt_load_row(a_wlr),
    .row_rd_en(a_rre), .row_rdaddr(a_rra), .row_wr_en(a_wre), .row_wraddr(a_wwa)
  );

  systolic_ws_ctrl #(.ROW_NUM(4), .COL_NUM(2), .LENGTH(3), .OUT_LAT(3)) dut_b (
    .clk(clk), .reset(rst_bc), .start_val(sv_b), .start_rdy(b_rdy), .done(b_done),
    .wt_rd_en(b_wrd), .wt_rdaddr(b_wra), .wt_load_en(b_wld), .wt_load_row(b_wlr),
    .row_rd_en(b_rre), .row_rdaddr(b_rra), .row_wr_en(b_wre), .row_wraddr(b_wwa)
  );

  systolic_ws_ctrl #(.ROW_NUM(1)) dut_c (
    .clk(clk), .reset(rst_bc), .start_val(sv_c), .start_rdy(c_rdy), .done(c_done),
    .wt_rd_en(c_wrd), .wt_rdaddr(c_wra), .wt_load_en(c_wld), .wt_load_row(c_wlr),
    .row_rd_en(c_rre), .row_rdaddr(c_rra), .row_wr_en(c_wre), .row_wraddr(c_wwa)
  );

  function automatic string kn(input int k);
    case (k)
      K_WRD:  return "wt_rd";
      K_WLD:  return "wt_load";
      K_RD:   return "row_rd";
      K_WR:   return "row_wr";
      default: return "done";
    endcase
  endfunction

  function automatic void chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
    else passed++;
  endfunction

  function automatic void push(input int sel, input int cy, input int kind, input int idx, input int addr);
    ev_t e;
    e.cyc = cy; e.kind = kind; e.idx = idx; e.addr = addr;
    case (sel)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endfunction

  // Expected events of one tile fired at cycle f, in monitor order; events at or after cut are dropped
  function automatic void push_tile(input int sel, input int f, input int l, input int r,
                                    input int c, input int o, input int cut);
    int b, fd;
    b  = f + l + 2;
    fd = f + (l + 1) + (o + c + r) + 1;
    for (int cy = f + 1; cy <= fd && cy < cut; cy++) begin
      int tt;
      tt = cy - b;
      if (cy - f - 1 < l) push(sel, cy, K_WRD, 0, cy - f - 1);
      if (cy - f - 2 >= 0 && cy - f - 2 < l) push(sel, cy, K_WLD, 0, cy - f - 2);
      for (int k = 0; k < l; k++)
        if (tt >= k && tt < k + r) push(sel, cy, K_RD, k, tt - k);
      for (int j = 0; j < c; j++)
        if (tt - 1 - o - j >= 0 && tt - 1 - o - j < r) push(sel, cy, K_WR, j, tt - 1 - o - j);
      if (cy == fd) push(sel, cy, K_DONE, 0, 0);
    end
  endfunction

  // Pop the next expected event of a DUT and compare with what it presents
  function automatic void got(input int sel, input int kind, input int idx, input int addr);
    ev_t e;
    bit  have;
    have = 1'b0;
    checks++;
    case (sel)
      0:       if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      1:       if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
    endcase
    if (!have)
      $display("FAIL dut%0d event: got %s[%0d] addr %0d at cycle %0d, required none",
               sel, kn(kind), idx, addr, cyc);
    else if (e.cyc != cyc || e.kind != kind || e.idx != idx || e.addr != addr)
      $display("FAIL dut%0d event: got %s[%0d] addr %0d at cycle %0d, required %s[%0d] addr %0d at cycle %0d",
               sel, kn(kind), idx, addr, cyc, kn(e.kind), e.idx, e.addr, e.cyc);
    else
      passed++;
  endfunction

  // Monitors: report every active enable/done, and demand zero addresses on idle lanes
  always @(negedge clk) begin
    logic stray;
    stray = 1'b0;
    if (a_wrd) got(0, K_WRD, 0, int'(a_wra)); else if (a_wra != 0) stray = 1'b1;
    if (a_wld) got(0, K_WLD, 0, int'(a_wlr)); else if (a_wlr != 0) stray = 1'b1;
    for (int k = 0; k < 8; k++)
      if (a_rre[k]) got(0, K_RD, k, int'(a_rra[k])); else if (a_rra[k] != 0) stray = 1'b1;
    for (int j = 0; j < 8; j++)
      if (a_wre[j]) got(0, K_WR, j, int'(a_wwa[j])); else if (a_wwa[j] != 0) stray = 1'b1;
    if (a_done) got(0, K_DONE, 0, 0);
    chk("dut0 idle_addr_zero", int'(stray), 0);
  end

  always @(negedge clk) begin
    logic stray;
    stray = 1'b0;
    if (b_wrd) got(1, K_WRD, 0, int'(b_wra)); else if (b_wra != 0) stray = 1'b1;
    if (b_wld) got(1, K_WLD, 0, int'(b_wlr)); else if (b_wlr != 0) stray = 1'b1;
    for (int k = 0; k < 3; k++)
      if (b_rre[k]) got(1, K_RD, k, int'(b_rra[k])); else if (b_rra[k] != 0) stray = 1'b1;
    for (int j = 0; j < 2; j++)
      if (b_wre[j]) got(1, K_WR, j, int'(b_wwa[j])); else if (b_wwa[j] != 0) stray = 1'b1;
    if (b_done) got(1, K_DONE, 0, 0);
    chk("dut1 idle_addr_zero", int'(stray), 0);
  end

  always @(negedge clk) begin
    logic stray;
    stray = 1'b0;
    if (c_wrd) got(2, K_WRD, 0, int'(c_wra)); else if (c_wra != 0) stray = 1'b1;
    if (c_wld) got(2, K_WLD, 0, int'(c_wlr)); else if (c_wlr != 0) stray = 1'b1;
    for (int k = 0; k < 8; k++)
      if (c_rre[k]) got(2, K_RD, k, int'(c_rra[k])); else if (c_rra[k] != 0) stray = 1'b1;
    for (int j = 0; j < 8; j++)
      if (c_wre[j]) got(2, K_WR, j, int'(c_wwa[j])); else if (c_wwa[j] != 0) stray = 1'b1;
    if (c_done) got(2, K_DONE, 0, 0);
    chk("dut2 idle_addr_zero", int'(stray), 0);
  end

  // Advance to 2 time units after the rising edge that starts cycle n
  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic int any_a();
    return int'(a_wrd | a_wld | (|a_rre) | (|a_wre) | a_done);
  endfunction

  initial begin
    rst_a = 1'b0; rst_bc = 1'b0;
    sv_a = 1'b0; sv_b = 1'b0; sv_c = 1'b0;

    // reset state
    go(1);
    chk("a rdy_in_reset", int'(a_rdy), 0);
    chk("a outs_in_reset", any_a(), 0);
    chk("b rdy_in_reset", int'(b_rdy), 0);
    go(2);
    rst_a = 1'b1; rst_bc = 1'b1;
    #1;
    chk("a rdy_after_reset", int'(a_rdy), 1);
    chk("c rdy_after_reset", int'(c_rdy), 1);

    // single tile on all three builds, fire at cycle 5
    go(5);
    sv_a = 1'b1; sv_b = 1'b1; sv_c = 1'b1;
    push_tile(0, 5, 8, 8, 8, 8, BIG);
    push_tile(1, 5, 3, 4, 2, 3, BIG);
    push_tile(2, 5, 8, 1, 8, 8, BIG);
    go(6);
    sv_a = 1'b0; sv_b = 1'b0; sv_c = 1'b0;
    chk("a rdy_busy", int'(a_rdy), 0);
    go(15);
    chk("b lane2_rd_en", int'(b_rre[2]), 1);
    chk("b lane2_rd_addr", int'(b_rra[2]), 3);
    chk("b col1_wr_en", int'(b_wre[1]), 1);
    chk("b col1_wr_addr", int'(b_wwa[1]), 0);
    go(19);
    chk("b done", int'(b_done), 1);
    go(24);
    chk("a col0_first_wr", int'(a_wre[0]), 1);
    chk("a col0_first_addr", int'(a_wwa[0]), 0);
    chk("a lane7_rd_addr", int'(a_rra[7]), 2);
    chk("c col0_wr", int'(c_wre[0]), 1);
    chk("c col1_wr", int'(c_wre[1]), 0);
    go(32);
    chk("c done", int'(c_done), 1);
    go(39);
    chk("a done", int'(a_done), 1);
    chk("a rdy_in_done", int'(a_rdy), 0);
    go(40);
    chk("a rdy_after_done", int'(a_rdy), 1);
    chk("a done_one_cycle", int'(a_done), 0);

    // start pulses during a run are dropped
    go(50);
    sv_a = 1'b1;
    push_tile(0, 50, 8, 8, 8, 8, BIG);
    go(51); sv_a = 1'b0;
    go(55); sv_a = 1'b1;
    go(56); sv_a = 1'b0;
    go(70); sv_a = 1'b1;
    go(71); sv_a = 1'b0;
    go(84);
    chk("a done_ignored_starts", int'(a_done), 1);
    go(85);
    chk("a rdy_ignored_starts", int'(a_rdy), 1);

    // start held high: back-to-back tiles
    go(100);
    sv_a = 1'b1;
    push_tile(0, 100, 8, 8, 8, 8, BIG);
    push_tile(0, 135, 8, 8, 8, 8, BIG);
    go(135);
    chk("a rdy_refire", int'(a_rdy), 1);
    go(136);
    sv_a = 1'b0;
    go(169);
    chk("a second_done", int'(a_done), 1);

    // reset in the middle of RUN, then a clean tile
    go(180);
    sv_a = 1'b1;
    push_tile(0, 180, 8, 8, 8, 8, 200);
    go(181);
    sv_a = 1'b0;
    go(200);
    rst_a = 1'b0;
    #1;
    chk("a outs_on_reset", any_a(), 0);
    chk("a rdy_on_reset", int'(a_rdy), 0);
    go(202);
    rst_a = 1'b1;
    #1;
    chk("a rdy_after_midreset", int'(a_rdy), 1);
    go(205);
    sv_a = 1'b1;
    push_tile(0, 205, 8, 8, 8, 8, BIG);
    go(206);
    sv_a = 1'b0;
    go(239);
    chk("a done_after_midreset", int'(a_done), 1);

    go(250);
    chk("a events_left", qa.size(), 0);
    chk("b events_left", qb.size(), 0);
    chk("c events_left", qc.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/systolic_ws_ctrl.md
Name: systolic_ws_ctrl

Overview:
- Sequencer for the weight-stationary systolic datapath (LENGTH rows x COL_NUM columns of PEs).
- On a start handshake it runs three phases in order:
  - loads LENGTH weight rows from the weight SRAM into the array's weight registers;
  - streams ROW_NUM input rows from the source SRAMs, skewed one cycle per lane;
  - writes ROW_NUM results per column into the result SRAMs, skewed one cycle per column.
- Pulses done when the last write has been issued.

Parameters:
- ROW_NUM, 8, input rows per tile; also result rows per column.
- COL_NUM, 8, number of array columns (result lanes).
- LENGTH, 8, number of array rows (input lanes, weight rows).
- OUT_LAT, 8, cycles from lane-0 data presented at the west port of array row 0 to the matching result at the south port of column 0.
- ROW_ADDR_WIDTH, max(1,$clog2(ROW_NUM)), derived.
- LENGTH_ADDR_WIDTH, max(1,$clog2(LENGTH)), derived.
- T_WIDTH, $clog2(OUT_LAT+COL_NUM+ROW_NUM+1), derived; width of the phase counter.

Ports:
- clk, input, 1, single clock; all logic is rising-edge.
- reset, input, 1, asynchronous, active-low.
- start_val, input, 1, request to run one tile.
- start_rdy, output, 1, controller idle and able to accept a start.
- done, output, 1, one-cycle pulse at the end of a tile.
- wt_rd_en, output, 1, weight SRAM read enable.
- wt_rdaddr, output, LENGTH_ADDR_WIDTH, weight SRAM row address.
- wt_load_en, output, 1, latches the weight SRAM data into array weight row wt_load_row.
- wt_load_row, output, LENGTH_ADDR_WIDTH, destination weight row for wt_load_en.
- row_rd_en, output, [0:LENGTH-1] x 1, per-lane source SRAM read enable.
- row_rdaddr, output, [0:LENGTH-1] x ROW_ADDR_WIDTH, per-lane source SRAM read address.
- row_wr_en, output, [0:COL_NUM-1] x 1, per-column result SRAM write enable.
- row_wraddr, output, [0:COL_NUM-1] x ROW_ADDR_WIDTH, per-column result SRAM write address.

Behaviour:
- All outputs are registered except start_rdy, which equals (state==IDLE) & reset.
- While reset is low, every output is 0, the state is IDLE and all counters are 0.
- Both SRAMs have a 1-cycle read latency.
- FSM states are IDLE, LOAD_W, RUN, DRAIN, DONE.
- IDLE:
  - start fires when start_val & start_rdy.
  - On fire, the next state is LOAD_W and counter c = 0.
- LOAD_W:
  - Lasts LENGTH+1 cycles, c = 0..LENGTH.
  - For c < LENGTH: wt_rd_en = 1 and wt_rdaddr = c.
  - For c >= 1: wt_load_en = 1 and wt_load_row = c-1.
  - After c = LENGTH the state moves to RUN with t = 0.
- RUN and DRAIN share the phase counter t, which increments by 1 every cycle.
  - Lane k: row_rd_en[k] = 1 iff k <= t < k+ROW_NUM, with row_rdaddr[k] = t-k.
  - Column j: row_wr_en[j] = 1 iff 1+OUT_LAT+j <= t < 1+OUT_LAT+j+ROW_NUM, with row_wraddr[j] = t-1-OUT_LAT-j.
  - When an enable is 0, its address is 0.
  - RUN becomes DRAIN when t = LENGTH+ROW_NUM-2, the last read cycle.
  - DRAIN becomes DONE after t = OUT_LAT+COL_NUM+ROW_NUM-1, the last write cycle.
  - If the last read is at or after the first write, DRAIN still begins after the last read.
- DONE: done = 1 for exactly one cycle, then IDLE. The total run from fire to the done cycle is (LENGTH+1)+(OUT_LAT+COL_NUM+ROW_NUM)+1 cycles.
- start_val outside IDLE is ignored and is not queued.
- start_val held high re-fires in the first IDLE cycle after DONE.
- Reset asserted mid-operation: all enables and done drop asynchronously, the FSM goes to IDLE, and no partial state is retained.
- Counters never wrap within a tile, because T_WIDTH covers the maximum t.
- Boundary ROW_NUM = 1: every lane and every column gets exactly one enable cycle, at address 0.

Test Plan:
1. Defaults, start_val pulsed with fire at cycle 0 ->
   - LOAD_W spans cycles 1-9; wt_load_en runs cycles 2-9 with rows 0-7.
   - row_rd_en[0] runs cycles 10-17; row_rd_en[7] runs cycles 17-24.
   - row_wr_en[0] runs cycles 19-26 (addresses 0-7); row_wr_en[7] runs cycles 26-33.
   - done = 1 at cycle 34 only; start_rdy = 1 at cycle 35.
2. start_val held high continuously -> the second fire occurs at cycle 35 and the second done at cycle 69; no overlap of enables between tiles.
3. start_val pulsed during cycles 5 and 20 of a run -> ignored; exactly one done pulse, at cycle 34.
4. reset driven low at cycle 20 (RUN), released at cycle 22 -> all enables are 0 from the reset edge; start_rdy = 1 from cycle 22; a new fire reproduces scenario 1 timing.
5. ROW_NUM=4, COL_NUM=2, LENGTH=3, OUT_LAT=3, fire at cycle 0 ->
   - LOAD_W spans cycles 1-4; lane 2 reads cycles 7-10.
   - Column 1 writes cycles 10-13 with addresses 0-3.
   - done at cycle 14.
6. ROW_NUM=1, defaults otherwise -> each row_rd_en[k] is high for a single cycle at 10+k; each row_wr_en[j] for a single cycle at 19+j; all addresses 0; done at cycle 27.
